up_to_target_bcd: RTL and testbench

- Cascadable multi-digit BCD up-counter: the counting-up counterpart of the timer's down-from-9 digit chain.
- Measures elapsed irrigation time in the timer block: counts enable ticks from a loaded start value toward a programmed BCD target.
- Flags completion and drives a carry to a further cascaded stage.

---
 rtl/timer_pkg.sv | 20 ++
 rtl/up_to_9.sv | 53 +++++
 rtl/up_to_target_bcd.sv | 97 +++++++++
 tb/tb_up_to_target_bcd.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the irrigation timer BCD digit counters.
//   DIGIT_W     : width of one BCD digit
//   DIGIT_MAX   : largest legal BCD digit value (9)
//   bcd_digit_t : one BCD digit
//   bcd_valid() : returns 1 when a digit is a legal BCD value (0..9)
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return (digit <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/up_to_9.sv
// ---------------------------------------------------------------------------
// up_to_9
// Single BCD digit counter, 0..9, for use in a ripple-carry digit chain.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous active-low reset (q -> 0)
//   clear      : synchronous clear (highest priority)
//   load       : synchronous load of load_digit (illegal digit loads as 0)
//   load_digit : BCD value to load
//   carry_in   : increment request from the lower digit (or the enable)
//   q          : current digit value
//   carry_out  : carry_in AND q==9, feeds the next digit up
// ---------------------------------------------------------------------------
module up_to_9
  import timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       carry_in,
  output logic [3:0] q,
  output logic       carry_out
);

  bcd_digit_t r_q;
  bcd_digit_t w_q_next;

  always_comb begin
    w_q_next = r_q;
    if (clear) begin
      w_q_next = '0;
    end else if (load) begin
      // A non-BCD load digit is replaced by 0 rather than propagated.
      w_q_next = bcd_valid(load_digit) ? load_digit : '0;
    end else if (carry_in) begin
      w_q_next = (r_q == DIGIT_MAX) ? '0 : r_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q         = r_q;
  assign carry_out = carry_in & (r_q == DIGIT_MAX);

endmodule

// File: rtl/up_to_target_bcd.sv
// ---------------------------------------------------------------------------
// up_to_target_bcd
// Cascadable multi-digit BCD up-counter that counts enable ticks from a
// loaded start value and flags when the count reaches a BCD target.
// Parameter:
//   DIGITS       : number of BCD digits (1..4)
// Ports:
//   clock        : system clock, rising edge
//   reset        : asynchronous active-low reset
//   enable       : count tick
//   clear        : synchronous clear of count and done (highest priority)
//   load         : synchronous load of load_value, clears done
//   load_value   : BCD start value, digit 0 in bits [3:0]
//   target       : BCD terminal value, sampled every cycle
//   q_bus        : current BCD count
//   trigger_next : combinational carry to a further cascaded stage
//   done         : sticky registered completion flag
// Build option:
//   UP_TO_TARGET_HOLD_AT_TARGET_EN : when defined, counting stops at the
//   target value and trigger_next stays low once the target is reached.
// ---------------------------------------------------------------------------
module up_to_target_bcd
  import timer_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [4*DIGITS-1:0]   target,
  output logic [4*DIGITS-1:0]   q_bus,
  output logic                  trigger_next,
  output logic                  done
);

  logic              r_done;
  logic              w_match;
  logic              w_target_valid;
  logic              w_count_en;
  logic [DIGITS:0]   w_carry;

  // A target containing a non-BCD digit can never be reached by the count.
  always_comb begin
    w_target_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(target[4*i +: 4])) begin
        w_target_valid = 1'b0;
      end
    end
  end

  assign w_match = (q_bus == target) & w_target_valid & ~r_done;

  // Clear/load suppress the count tick so that trigger_next cannot pulse
  // in a cycle whose counter update is overridden.
`ifdef UP_TO_TARGET_HOLD_AT_TARGET_EN
  // Also stop on the match cycle itself so the count freezes at target.
  assign w_count_en = enable & ~clear & ~load & ~r_done & ~w_match;
`else
  assign w_count_en = enable & ~clear & ~load;
`endif

  assign w_carry[0] = w_count_en;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      up_to_9 u_digit (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .load       (load),
        .load_digit (load_value[4*gi +: 4]),
        .carry_in   (w_carry[gi]),
        .q          (q_bus[4*gi +: 4]),
        .carry_out  (w_carry[gi+1])
      );
    end
  endgenerate

  assign trigger_next = w_carry[DIGITS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
    end else if (clear || load) begin
      r_done <= 1'b0;
    end else if (w_match) begin
      r_done <= 1'b1;
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_up_to_target_bcd.sv
// ---------------------------------------------------------------------------
// tb_up_to_target_bcd
// Directed self-checking bench for up_to_target_bcd with DIGITS=2.
// ---------------------------------------------------------------------------
module tb_up_to_target_bcd;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       clear;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] target;
  logic [7:0] q_bus;
  logic       trigger_next;
  logic       done;

  int n_vec;
  int n_miscmp;

  up_to_target_bcd #(.DIGITS(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .load         (load),
    .load_value   (load_value),
    .target       (target),
    .q_bus        (q_bus),
    .trigger_next (trigger_next),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   trig_cnt;
    logic done_seen;
    int   cnt;

    n_vec = 0;
    n_miscmp = 0;
    reset = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    load = 1'b0;
    load_value = 8'h00;
    target = 8'hAA;

    #12;
    chk("reset_q", {24'h0, q_bus}, 32'h00);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_trig", {31'h0, trigger_next}, 32'h0);
    reset = 1'b1;

    // Count with carry between digits.
    load = 1'b1; load_value = 8'h08;
    tick();
    chk("load_08", {24'h0, q_bus}, 32'h08);
    load = 1'b0; enable = 1'b1;
    #1 chk("cnt_trig_a", {31'h0, trigger_next}, 32'h0);
    tick(); chk("cnt_09", {24'h0, q_bus}, 32'h09);
    chk("cnt_trig_b", {31'h0, trigger_next}, 32'h0);
    tick(); chk("cnt_10", {24'h0, q_bus}, 32'h10);
    chk("cnt_trig_c", {31'h0, trigger_next}, 32'h0);
    tick(); chk("cnt_11", {24'h0, q_bus}, 32'h11);
    enable = 1'b0;

    // Asynchronous reset in the middle of a cycle, with done set.
    load = 1'b1; load_value = 8'h37; target = 8'h37;
    tick(); chk("load_37", {24'h0, q_bus}, 32'h37);
    load = 1'b0;
    tick(); chk("done_37", {31'h0, done}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_q", {24'h0, q_bus}, 32'h00);
    chk("async_rst_done", {31'h0, done}, 32'h0);
    reset = 1'b1; target = 8'hAA;

    // Wrap from 99 and invalid-digit load.
    load = 1'b1; load_value = 8'h99;
    tick(); chk("load_99", {24'h0, q_bus}, 32'h99);
    load = 1'b0; enable = 1'b1;
    #1 chk("wrap_trig", {31'h0, trigger_next}, 32'h1);
    tick(); chk("wrap_q", {24'h0, q_bus}, 32'h00);
    chk("wrap_trig_after", {31'h0, trigger_next}, 32'h0);
    enable = 1'b0;
    load = 1'b1; load_value = 8'h9A;
    tick(); chk("load_9A", {24'h0, q_bus}, 32'h90);
    load = 1'b0; clear = 1'b1;
    tick(); chk("clear_q", {24'h0, q_bus}, 32'h00);
    clear = 1'b0;

    // Reaching the target.
    target = 8'h05; load = 1'b1; load_value = 8'h00;
    tick(); chk("tgt_load", {24'h0, q_bus}, 32'h00);
    chk("tgt_done0", {31'h0, done}, 32'h0);
    load = 1'b0; enable = 1'b1;
    repeat (5) tick();
    chk("tgt_q05", {24'h0, q_bus}, 32'h05);
    chk("tgt_done_pre", {31'h0, done}, 32'h0);
    tick();
    chk("tgt_done_rise", {31'h0, done}, 32'h1);
`ifdef UP_TO_TARGET_HOLD_AT_TARGET_EN
    chk("tgt_hold_a", {24'h0, q_bus}, 32'h05);
    tick();
    chk("tgt_hold_b", {24'h0, q_bus}, 32'h05);
    chk("tgt_hold_trig", {31'h0, trigger_next}, 32'h0);
`else
    chk("tgt_run_06", {24'h0, q_bus}, 32'h06);
    tick();
    chk("tgt_run_07", {24'h0, q_bus}, 32'h07);
`endif
    chk("tgt_done_sticky", {31'h0, done}, 32'h1);
    enable = 1'b0;

    // Priority: clear over load over enable, with a live match at 99.
    target = 8'h99; load = 1'b1; load_value = 8'h99;
    tick(); chk("pri_load99", {24'h0, q_bus}, 32'h99);
    chk("pri_done_cleared", {31'h0, done}, 32'h0);
    clear = 1'b1; load = 1'b1; load_value = 8'h33; enable = 1'b1;
    #1 chk("pri_trig_forced", {31'h0, trigger_next}, 32'h0);
    tick();
    chk("pri_clear_q", {24'h0, q_bus}, 32'h00);
    chk("pri_clear_done", {31'h0, done}, 32'h0);
    clear = 1'b0; load_value = 8'h42;
    tick(); chk("pri_load_q", {24'h0, q_bus}, 32'h42);
    load = 1'b0; enable = 1'b0; target = 8'h42;
    tick(); chk("done_no_enable", {31'h0, done}, 32'h1);
    chk("hold_q42", {24'h0, q_bus}, 32'h42);

    // Invalid target: two full passes through 00..99.
    target = 8'hA0; clear = 1'b1;
    tick(); chk("inv_clear", {24'h0, q_bus}, 32'h00);
    clear = 1'b0; enable = 1'b1;
    trig_cnt = 0; done_seen = 1'b0; cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (trigger_next) trig_cnt++;
      tick();
      cnt = (cnt + 1) % 100;
      if (done) done_seen = 1'b1;
      chk("inv_q", {24'h0, q_bus}, {24'h0, 4'(cnt / 10), 4'(cnt % 10)});
    end
    enable = 1'b0;
    chk("inv_trig_count", trig_cnt, 2);
    chk("inv_done_never", {31'h0, done_seen}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
